// File: rtl/mmio_io_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_hub
// Purpose  : Memory-mapped I/O hub: RAM/IO decode, debounced buttons with
//            sticky W1C events, synchronised switches, VGA/7-seg registers
//            and a prescaled tick timer.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_hub #(
  parameter int          NBTN      = 4,
  parameter int          NSW       = 2,
  parameter int          DB_CYCLES = 250000,
  parameter logic [31:0] IO_BASE   = 32'h0000_0400,
  parameter int          TICK_DIV  = 25000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             cs,
  input  logic             sig_w,
  input  logic             sig_r,
  input  logic [31:0]      wdata,
  input  logic [31:0]      data_fmem,
  input  logic [NBTN-1:0]  btn,
  input  logic [NSW-1:0]   sw,
  output logic [31:0]      rdata,
  output logic             ram_we,
  output logic [31:0]      data_tovga,
  output logic [31:0]      data_toseg7,
  output logic             seg7_cs,
  output logic             tick_irq
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

  localparam logic [3:0] REG_BTN_LVL = 4'd0;
  localparam logic [3:0] REG_BTN_EVT = 4'd1;
  localparam logic [3:0] REG_SW      = 4'd2;
  localparam logic [3:0] REG_VGA     = 4'd3;
  localparam logic [3:0] REG_SEG     = 4'd4;
  localparam logic [3:0] REG_TICK    = 4'd5;

  // Window test by subtraction so IO_BASE needs no particular alignment.
  logic [31:0] io_off;
  logic        is_io;
  logic [3:0]  reg_idx;
  logic        io_wr;

  assign io_off  = addr - IO_BASE;
  assign is_io   = (io_off < 32'd64);
  assign reg_idx = io_off[5:2];
  assign io_wr   = cs & sig_w & is_io;
  assign ram_we  = cs & sig_w & ~is_io;

  logic [NBTN-1:0] btn_s1, btn_s2;
  logic [NSW-1:0]  sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  logic [NBTN-1:0] btn_lvl;
  logic [NBTN-1:0] btn_flip;
  logic [NBTN-1:0] btn_rise;
  logic [NBTN-1:0] btn_evt;

  generate
    for (genvar i = 0; i < NBTN; i++) begin : g_db
      logic [DBW-1:0] cnt;
      logic           differs;

      assign differs     = (btn_s2[i] != btn_lvl[i]);
      assign btn_flip[i] = differs && (cnt == DB_LAST);

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
        end else if (!differs || (cnt == DB_LAST)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + DBW'(1);
        end
      end
    end
  endgenerate

  assign btn_rise = btn_flip & ~btn_lvl;

  // A rising edge in the same cycle as a W1C on that bit keeps the bit set.
  logic [NBTN-1:0] evt_clr;
  assign evt_clr = (io_wr && (reg_idx == REG_BTN_EVT)) ? wdata[NBTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_lvl <= '0;
      btn_evt <= '0;
    end else begin
      btn_lvl <= btn_lvl ^ btn_flip;
      btn_evt <= (btn_evt & ~evt_clr) | btn_rise;
    end
  end

  logic [31:0]    vga_reg;
  logic [31:0]    seg_reg;
  logic [31:0]    tick_reg;
  logic [PSW-1:0] presc;
  logic           seg_cs_r;
  logic           irq_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_reg  <= '0;
      seg_reg  <= '0;
      seg_cs_r <= 1'b0;
      tick_reg <= '0;
      presc    <= '0;
      irq_r    <= 1'b0;
    end else begin
      seg_cs_r <= io_wr && (reg_idx == REG_SEG);
      if (io_wr && (reg_idx == REG_VGA)) begin
        vga_reg <= wdata;
      end
      if (io_wr && (reg_idx == REG_SEG)) begin
        seg_reg <= wdata;
      end
      // A software load restarts the prescaler and swallows this cycle's tick.
      if (io_wr && (reg_idx == REG_TICK)) begin
        tick_reg <= wdata;
        presc    <= '0;
        irq_r    <= 1'b0;
      end else if (presc == PS_LAST) begin
        tick_reg <= tick_reg + 32'd1;
        presc    <= '0;
        irq_r    <= 1'b1;
      end else begin
        presc    <= presc + PSW'(1);
        irq_r    <= 1'b0;
      end
    end
  end

  assign data_tovga  = vga_reg;
  assign data_toseg7 = seg_reg;
  assign seg7_cs     = seg_cs_r;
  assign tick_irq    = irq_r;

  always_comb begin
    rdata = '0;
    if (cs && sig_r) begin
      if (!is_io) begin
        rdata = data_fmem;
      end else begin
        case (reg_idx)
          REG_BTN_LVL: rdata = 32'(btn_lvl);
          REG_BTN_EVT: rdata = 32'(btn_evt);
          REG_SW:      rdata = 32'(sw_s2);
          REG_VGA:     rdata = vga_reg;
          REG_SEG:     rdata = seg_reg;
          REG_TICK:    rdata = tick_reg;
          default:     rdata = '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_hub
// Purpose  : Directed plus randomised checks of mmio_io_hub against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_io_hub;

  localparam int          NBTN = 4;
  localparam int          NSW  = 2;
  localparam int          DB   = 4;
  localparam int          TD   = 3;
  localparam logic [31:0] IOB  = 32'h0000_0400;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     addr, wdata, data_fmem;
  logic            cs, sig_w, sig_r;
  logic [NBTN-1:0] btn;
  logic [NSW-1:0]  sw;
  logic [31:0]     rdata, data_tovga, data_toseg7;
  logic            ram_we, seg7_cs, tick_irq;

  mmio_io_hub #(
    .NBTN(NBTN), .NSW(NSW), .DB_CYCLES(DB), .IO_BASE(IOB), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .cs(cs), .sig_w(sig_w),
    .sig_r(sig_r), .wdata(wdata), .data_fmem(data_fmem), .btn(btn), .sw(sw),
    .rdata(rdata), .ram_we(ram_we), .data_tovga(data_tovga),
    .data_toseg7(data_toseg7), .seg7_cs(seg7_cs), .tick_irq(tick_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [NBTN-1:0] bp0 = '0, bp1 = '0;
  logic [NSW-1:0]  sp0 = '0, sp1 = '0;
  logic [NBTN-1:0] win[$];
  logic [NBTN-1:0] lvl_m = '0, evt_m = '0;
  logic [31:0]     vga_m = '0, seg_m = '0, tick_m = '0;
  logic            segcs_m = 1'b0, irq_m = 1'b0;
  int              since_load = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic in_io(input logic [31:0] a);
    logic [31:0] o;
    o = a - IOB;
    return (o < 32'd64);
  endfunction

  function automatic logic [3:0] idx_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - IOB;
    return o[5:2];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!(cs && sig_r)) return 32'd0;
    if (!in_io(addr)) return data_fmem;
    case (idx_of(addr))
      4'd0:    return 32'(lvl_m);
      4'd1:    return 32'(evt_m);
      4'd2:    return 32'(sp1);
      4'd3:    return vga_m;
      4'd4:    return seg_m;
      4'd5:    return tick_m;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_edge();
    logic [NBTN-1:0] used, flip, rise, clr;
    logic            io_w, all_diff;
    logic [3:0]      idx;
    if (reset) begin
      bp0 = '0; bp1 = '0; sp0 = '0; sp1 = '0;
      win.delete();
      lvl_m = '0; evt_m = '0; vga_m = '0; seg_m = '0; tick_m = '0;
      segcs_m = 1'b0; irq_m = 1'b0; since_load = 0;
    end else begin
      io_w = cs && sig_w && in_io(addr);
      idx  = idx_of(addr);
      used = bp1; bp1 = bp0; bp0 = btn;
      sp1  = sp0; sp0 = sw;
      win.push_back(used);
      if (win.size() > DB) void'(win.pop_front());
      flip = '0;
      if (win.size() == DB) begin
        for (int i = 0; i < NBTN; i++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][i] == lvl_m[i]) all_diff = 1'b0;
          flip[i] = all_diff;
        end
      end
      rise  = flip & ~lvl_m;
      lvl_m = lvl_m ^ flip;
      clr   = (io_w && idx == 4'd1) ? wdata[NBTN-1:0] : '0;
      evt_m = (evt_m & ~clr) | rise;
      segcs_m = io_w && (idx == 4'd4);
      if (io_w && idx == 4'd3) vga_m = wdata;
      if (io_w && idx == 4'd4) seg_m = wdata;
      if (io_w && idx == 4'd5) begin
        tick_m = wdata; since_load = 0; irq_m = 1'b0;
      end else begin
        since_load++;
        if (since_load % TD == 0) begin
          tick_m = tick_m + 32'd1; irq_m = 1'b1;
        end else begin
          irq_m = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    chk("rdata", rdata, exp_rdata());
    chk("ram_we", 32'(ram_we), 32'(cs && sig_w && !in_io(addr)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("vga", data_tovga, vga_m);
    chk("seg", data_toseg7, seg_m);
    chk("seg7_cs", 32'(seg7_cs), 32'(segcs_m));
    chk("tick_irq", 32'(tick_irq), 32'(irq_m));
  endtask

  task automatic idle();
    cs = 1'b0; sig_w = 1'b0; sig_r = 1'b0;
    addr = $urandom; wdata = $urandom; data_fmem = $urandom;
    cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; sig_w = 1'b1; sig_r = 1'b0; addr = a; wdata = d; data_fmem = $urandom;
    cyc();
  endtask

  task automatic rd_lit(input logic [31:0] a, input logic [31:0] fm,
                        input logic [31:0] exp, input string tag);
    cs = 1'b1; sig_w = 1'b0; sig_r = 1'b1; addr = a; data_fmem = fm; wdata = $urandom;
    #1;
    chk(tag, rdata, exp);
    cyc();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    reset = 1'b1; btn = '0; sw = '0;
    cs = 1'b0; sig_w = 1'b0; sig_r = 1'b0; addr = '0; wdata = '0; data_fmem = '0;
    @(negedge clk);
    repeat (3) idle();
    chk("rst_vga", data_tovga, 32'd0);
    chk("rst_irq", 32'(tick_irq), 32'd0);
    reset = 1'b0;

    // Debounce of a held press
    repeat (10) idle();
    btn = 4'b0010;
    repeat (5) idle();
    rd_lit(IOB + 32'h00, 32'd0, 32'h0, "lvl_before");
    rd_lit(IOB + 32'h00, 32'd0, 32'h2, "lvl_at16");
    rd_lit(IOB + 32'h04, 32'd0, 32'h2, "evt_at16");

    // Short glitch on btn[0]
    btn = 4'b0011;
    repeat (3) idle();
    btn = 4'b0010;
    repeat (8) idle();
    rd_lit(IOB + 32'h00, 32'd0, 32'h2, "glitch_lvl");
    rd_lit(IOB + 32'h04, 32'd0, 32'h2, "glitch_evt");

    // W1C colliding with a new edge, then a clean W1C
    btn = 4'b0000;
    repeat (8) idle();
    rd_lit(IOB + 32'h00, 32'd0, 32'h0, "released");
    btn = 4'b0010;
    repeat (5) idle();
    wr(IOB + 32'h04, 32'h2);
    rd_lit(IOB + 32'h04, 32'd0, 32'h2, "w1c_race");
    wr(IOB + 32'h04, 32'h2);
    rd_lit(IOB + 32'h04, 32'd0, 32'h0, "w1c_clear");

    // Switch sync
    sw = 2'b10;
    repeat (2) idle();
    rd_lit(IOB + 32'h08, 32'd0, 32'h2, "sw");

    // 7-segment register and strobe
    cs = 1'b1; sig_w = 1'b1; sig_r = 1'b0; addr = IOB + 32'h10; wdata = 32'h1234;
    #1;
    chk("seg_ram_we", 32'(ram_we), 32'd0);
    cyc();
    chk("seg_data", data_toseg7, 32'h1234);
    chk("seg_cs_on", 32'(seg7_cs), 32'd1);
    idle();
    chk("seg_cs_off", 32'(seg7_cs), 32'd0);
    wr(IOB + 32'h10, 32'hA);
    wr(IOB + 32'h10, 32'hB);
    chk("seg_b2b", 32'(seg7_cs), 32'd1);

    // RAM path and unmapped hole
    cs = 1'b1; sig_w = 1'b1; sig_r = 1'b0; addr = 32'h8; wdata = 32'h77;
    #1;
    chk("ram_we_on", 32'(ram_we), 32'd1);
    cyc();
    rd_lit(32'h8, 32'hCAFE, 32'hCAFE, "ram_rd");
    rd_lit(IOB + 32'h3C, 32'hDEAD, 32'h0, "hole_rd");

    // Tick timer from reset
    reset = 1'b1; idle(); reset = 1'b0;
    idle(); idle();
    chk("irq_pre", 32'(tick_irq), 32'd0);
    idle();
    chk("irq_1", 32'(tick_irq), 32'd1);
    rd_lit(IOB + 32'h14, 32'd0, 32'd1, "tick_1");
    idle(); idle();
    chk("irq_2", 32'(tick_irq), 32'd1);
    rd_lit(IOB + 32'h14, 32'd0, 32'd2, "tick_2");

    // Tick wrap after a full load
    wr(IOB + 32'h14, 32'hFFFF_FFFF);
    chk("irq_load", 32'(tick_irq), 32'd0);
    idle(); idle(); idle();
    chk("irq_wrap", 32'(tick_irq), 32'd1);
    rd_lit(IOB + 32'h14, 32'd0, 32'd0, "tick_wrap");

    // Reset mid-count, with btn[1] still held through it
    wr(IOB + 32'h0C, 32'h55);
    chk("vga_55", data_tovga, 32'h55);
    idle();
    reset = 1'b1; idle(); idle();
    chk("mid_vga", data_tovga, 32'd0);
    chk("mid_seg", data_toseg7, 32'd0);
    chk("mid_segcs", 32'(seg7_cs), 32'd0);
    chk("mid_irq", 32'(tick_irq), 32'd0);
    reset = 1'b0;
    idle(); idle();
    rd_lit(IOB + 32'h14, 32'd0, 32'd0, "tick_r2");
    rd_lit(IOB + 32'h14, 32'd0, 32'd1, "tick_r3");
    idle(); idle();
    rd_lit(IOB + 32'h04, 32'd0, 32'h2, "held_evt");

    // Randomised traffic checked cycle by cycle against the model
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 5) == 0) btn = NBTN'($urandom);
      if ($urandom_range(0, 3) == 0) sw = NSW'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0:       a = IOB - 32'd4;
        1:       a = IOB + 32'd64;
        2:       a = 32'($urandom_range(0, 255)) << 2;
        default: a = IOB + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      endcase
      op = $urandom_range(0, 9);
      addr = a; wdata = $urandom; data_fmem = $urandom;
      cs    = (op >= 3) || ($urandom_range(0, 3) == 0);
      sig_r = (op >= 3 && op <= 5);
      sig_w = (op >= 6);
      cyc();
    end
    reset = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
